// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake between a value producer and the 7-segment scan controller.
// The producer drives value, dots and LOAD; the controller answers with LOAD_ACK.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] VAL_IN;
    logic [DIGITS-1:0]   DP_IN;
    logic                LOAD;
    logic                LOAD_ACK;

    modport master (
        output VAL_IN,
        output DP_IN,
        output LOAD,
        input  LOAD_ACK
    );

    modport slave (
        input  VAL_IN,
        input  DP_IN,
        input  LOAD,
        output LOAD_ACK
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with blank gaps,
// frame-synchronous double buffering and optional leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic              CLK,
    input  logic              RST,
    seg7_scan_ctrl_if.slave   ld,
    input  logic              LZB,
    output logic [3:0]        NIBBLE,
    input  logic [6:0]        SEG_IN,
    output logic [7:0]        SEG,
    output logic [DIGITS-1:0] AN,
    output logic              FRAME
);
    localparam int MAXC = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(DIGITS);

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    logic [0:0]          state;
    logic [IW-1:0]       idx;
    logic [CW-1:0]       cnt;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_dp;
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend;
    logic                load_ack;

    logic [DIGITS-1:0]   blanked;
    logic                all_zero;
    logic                blank_last;
    logic                drive_last;
    logic                last_idx;
    logic                boundary;
    logic [7:0]          seg_data;

    assign NIBBLE      = 4'(sh_val >> {idx, 2'b00});
    assign ld.LOAD_ACK = load_ack;

    // Walk from the top digit down; a digit blanks only if it and all above are zero.
    always_comb begin
        blanked  = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero & (sh_val[4*i +: 4] == 4'h0);
            if (i != 0)
                blanked[i] = LZB & all_zero;
        end
    end

    assign blank_last = (cnt == CW'(BLANK_CYC - 1));
    assign drive_last = (cnt == CW'(PRESCALE - 1));
    assign last_idx   = (idx == IW'(DIGITS - 1));
    assign boundary   = (state == S_DRIVE) && drive_last && last_idx;
    assign seg_data   = {~sh_dp[idx], blanked[idx] ? 7'h7F : SEG_IN};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_BLANK;
            idx      <= '0;
            cnt      <= '0;
            sh_val   <= '0;
            sh_dp    <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            pend     <= 1'b0;
            AN       <= '1;
            SEG      <= 8'hFF;
            load_ack <= 1'b0;
            FRAME    <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            FRAME    <= 1'b0;

            if (ld.LOAD) begin
                pend_val <= ld.VAL_IN;
                pend_dp  <= ld.DP_IN;
                pend     <= 1'b1;
            end

            unique case (state)
                S_BLANK: begin
                    if (blank_last) begin
                        cnt   <= '0;
                        AN    <= ~(DIGITS'(1) << idx);
                        SEG   <= seg_data;
                        state <= S_DRIVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (drive_last) begin
                        cnt   <= '0;
                        AN    <= '1;
                        SEG   <= 8'hFF;
                        idx   <= last_idx ? '0 : idx + 1'b1;
                        state <= S_BLANK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_BLANK;
            endcase

            // A LOAD on the boundary edge bypasses the pending register.
            if (boundary) begin
                FRAME <= 1'b1;
                if (pend || ld.LOAD) begin
                    sh_val   <= ld.LOAD ? ld.VAL_IN : pend_val;
                    sh_dp    <= ld.LOAD ? ld.DP_IN  : pend_dp;
                    pend     <= 1'b0;
                    load_ack <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: scan timing, double buffering,
// leading-zero blanking, boundary loads and reset recovery.
module tb_seg7_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       lzb;
    logic [3:0] nibble;
    logic [6:0] seg_in;
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame;

    int n_chk  = 0;
    int n_pass = 0;

    seg7_scan_ctrl_if #(.DIGITS(4)) ld ();

    seg7_scan_ctrl #(
        .DIGITS   (4),
        .PRESCALE (4),
        .BLANK_CYC(2)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .ld    (ld.slave),
        .LZB   (lzb),
        .NIBBLE(nibble),
        .SEG_IN(seg_in),
        .SEG   (seg),
        .AN    (an),
        .FRAME (frame)
    );

    always #5 clk = ~clk;

    // Shared decoder model, gfedcba active-low.
    always_comb begin
        seg_in = 7'h7F;
        case (nibble)
            4'h0: seg_in = 7'h40;
            4'h1: seg_in = 7'h79;
            4'h2: seg_in = 7'h24;
            4'h3: seg_in = 7'h30;
            4'h4: seg_in = 7'h19;
            4'h5: seg_in = 7'h12;
            4'h6: seg_in = 7'h02;
            4'h7: seg_in = 7'h78;
            4'h8: seg_in = 7'h00;
            4'h9: seg_in = 7'h10;
            4'hA: seg_in = 7'h08;
            4'hB: seg_in = 7'h03;
            4'hC: seg_in = 7'h46;
            4'hD: seg_in = 7'h21;
            4'hE: seg_in = 7'h06;
            4'hF: seg_in = 7'h0E;
            default: seg_in = 7'h7F;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        ld.VAL_IN = v;
        ld.DP_IN  = d;
        ld.LOAD   = 1'b1;
        @(negedge clk);
        ld.LOAD   = 1'b0;
    endtask

    task automatic wait_digit(input int d, output logic [7:0] s);
        logic [3:0] mask;
        bit found;
        mask  = ~(4'b0001 << d);
        found = 1'b0;
        s     = 8'hXX;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (an == mask) begin
                found = 1'b1;
                s     = seg;
            end
        end
        chk($sformatf("digit%0d_seen", d), 32'(found), 32'd1);
    endtask

    task automatic wait_frame(output int acks);
        bit found;
        found = 1'b0;
        acks  = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (ld.LOAD_ACK) acks++;
            if (frame) found = 1'b1;
        end
        chk("frame_seen", 32'(found), 32'd1);
    endtask

    logic [7:0] s;
    int         acks;
    logic [3:0] an_exp [8];

    initial begin
        rst       = 1'b1;
        lzb       = 1'b0;
        ld.VAL_IN = '0;
        ld.DP_IN  = '0;
        ld.LOAD   = 1'b0;
        an_exp    = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};

        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_ack", 32'(ld.LOAD_ACK), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);
        rst = 1'b0;

        // Scan timing from reset release
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("scan_an_%0d", i), 32'(an), 32'(an_exp[i]));
            if (i == 1) chk("scan_seg_d0", 32'(seg), 32'hC0);
        end

        // Mid-frame load only shows after the boundary
        load(16'h1234, 4'b0000);
        chk("hold_seg_d1", 32'(seg), 32'hC0);
        wait_frame(acks);
        chk("ld1_acks", 32'(acks), 32'd1);
        chk("ld1_ack_at_frame", 32'(ld.LOAD_ACK), 32'd1);
        @(negedge clk);
        chk("ld1_ack_once", 32'(ld.LOAD_ACK), 32'd0);
        chk("ld1_frame_once", 32'(frame), 32'd0);
        wait_digit(0, s); chk("v1234_d0", 32'(s), 32'h99);
        wait_digit(1, s); chk("v1234_d1", 32'(s), 32'hB0);
        wait_digit(2, s); chk("v1234_d2", 32'(s), 32'hA4);
        wait_digit(3, s); chk("v1234_d3", 32'(s), 32'hF9);

        // Leading-zero blanking
        lzb = 1'b1;
        load(16'h0050, 4'b0000);
        wait_frame(acks);
        wait_digit(0, s); chk("lzb50_d0", 32'(s), 32'hC0);
        wait_digit(1, s); chk("lzb50_d1", 32'(s), 32'h92);
        wait_digit(2, s); chk("lzb50_d2", 32'(s), 32'hFF);
        wait_digit(3, s); chk("lzb50_d3", 32'(s), 32'hFF);
        load(16'h0000, 4'b0000);
        wait_frame(acks);
        wait_digit(0, s); chk("lzb0_d0", 32'(s), 32'hC0);
        wait_digit(1, s); chk("lzb0_d1", 32'(s), 32'hFF);
        wait_digit(2, s); chk("lzb0_d2", 32'(s), 32'hFF);
        wait_digit(3, s); chk("lzb0_d3", 32'(s), 32'hFF);
        lzb = 1'b0;

        // Two loads in one frame: latest wins, single ack
        load(16'hAAAA, 4'b0000);
        load(16'hBEEF, 4'b0001);
        wait_frame(acks);
        chk("beef_acks", 32'(acks), 32'd1);
        wait_digit(0, s); chk("beef_d0", 32'(s), 32'h0E);
        wait_digit(3, s);
        chk("beef_d3_seg", 32'(s[6:0]), 32'h03);
        chk("beef_d3_dp", 32'(s[7]), 32'd1);
        wait_frame(acks);
        chk("beef_no_reack", 32'(acks), 32'd0);

        // Load on the boundary edge itself
        wait_digit(3, s);
        repeat (3) @(negedge clk);
        load(16'h4321, 4'b0000);
        chk("bnd_frame", 32'(frame), 32'd1);
        chk("bnd_ack", 32'(ld.LOAD_ACK), 32'd1);
        wait_digit(0, s); chk("v4321_d0", 32'(s), 32'hF9);
        wait_digit(3, s); chk("v4321_d3", 32'(s), 32'h99);

        // Reset with a pending load discards it
        wait_digit(0, s);
        load(16'h7777, 4'b1111);
        wait_digit(2, s);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'hFF);
        chk("mrst_ack", 32'(ld.LOAD_ACK), 32'd0);
        wait_digit(0, s); chk("mrst_d0", 32'(s), 32'hC0);
        wait_frame(acks);
        chk("mrst_no_ack", 32'(acks), 32'd0);
        wait_digit(0, s); chk("mrst_d0_next", 32'(s), 32'hC0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Shares a single external combinational hex-to-7seg decoder (segment order gfedcba, active-low) across DIGITS digits.
- Sequences digit enables with an anti-ghosting blank gap between digits.
- Double-buffers display values so updates commit only at frame boundaries; optional leading-zero blanking.

Parameters:
- DIGITS, 4, number of digits scanned (2..8).
- PRESCALE, 50000, CLK cycles each digit is driven (>=1).
- BLANK_CYC, 16, CLK cycles all digits are off between slots (>=1).

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- VAL_IN  in  4*DIGITS  hex value; nibble i is digit i, digit 0 is the least significant.
- DP_IN  in  DIGITS  decimal point per digit; 1 = dot lit.
- LOAD  in  1  capture VAL_IN/DP_IN on the cycle it is high.
- LZB  in  1  1 = leading-zero blanking enabled (level, sampled live).
- NIBBLE  out  4  to shared decoder: shadow nibble of the current digit index (combinational from registers).
- SEG_IN  in  7  from shared decoder: gfedcba, 0 = lit.
- SEG  out  8  registered {dp, g..a}, active-low.
- AN  out  DIGITS  registered digit enables, active-low.
- LOAD_ACK  out  1  one-cycle pulse: a pending value has been committed to the shadow.
- FRAME  out  1  one-cycle pulse at every frame boundary.

Behaviour:
- Reset (sync, RST=1 at a rising edge):
  - state=BLANK, idx=0, counter=0.
  - shadow VAL=0, DP=0; pending cleared.
  - AN=all 1, SEG=8'hFF, LOAD_ACK=0, FRAME=0.
  - Reset mid-operation discards pending data; no LOAD_ACK is issued.
- States and transitions:
  - BLANK: AN=all 1, SEG=FF. Counts 0..BLANK_CYC-1. On the last count, registers AN<=~(1<<idx) and SEG<=digit data, then goes to DRIVE. Decoded segments are therefore valid on the first DRIVE cycle.
  - DRIVE: AN holds a single low bit. Counts 0..PRESCALE-1. On the last count, registers AN<=all 1 and SEG<=FF, sets idx<=idx+1 (wrapping DIGITS-1 -> 0), then goes to BLANK.
- Timing:
  - Slot = BLANK_CYC+PRESCALE cycles; frame = DIGITS*slot cycles.
  - Scan order: 0,1,..,DIGITS-1, then wrap.
- Digit data: SEG = {~DP_shadow[idx], SEG_IN}, unless the digit is blanked, in which case SEG = {~DP_shadow[idx], 7'h7F].
- Leading-zero blanking (LZB=1):
  - Digit i>0 is blanked iff all shadow nibbles i..DIGITS-1 are 0.
  - Digit 0 is never blanked.
  - AN is still driven low for a blanked digit; only segments a-g are forced off.
- NIBBLE = shadow nibble at idx at all times. It changes at the DRIVE->BLANK edge, so the decoder settles during BLANK.
- Load handshake:
  - LOAD=1 writes VAL_IN/DP_IN into the pending register and sets pending=1.
  - Later LOADs before commit overwrite it (latest wins).
- Frame boundary: the edge leaving the last DRIVE cycle with idx=DIGITS-1.
  - At this edge, if pending=1 or LOAD=1, shadow <= (LOAD ? VAL_IN/DP_IN : pending data) and pending is cleared.
  - LOAD coincident with the boundary edge is committed directly.
  - LOAD_ACK=1 in the cycle after a commit edge, otherwise 0.
  - FRAME=1 in the cycle after every boundary edge.
- The shadow never changes except at a boundary edge or reset, so there is no tearing within a frame.
- Counters are sized $clog2 of the larger of PRESCALE and BLANK_CYC, with no overflow.

Test Plan (DIGITS=4, PRESCALE=4, BLANK_CYC=2; slot 6, frame 24 cycles):
1. Release RST, then observe:
   - AN=1111, SEG=FF for 2 cycles.
   - Then AN=1110, SEG=8'hC0 (digit '0') for 4 cycles, followed by 2 blank cycles and AN=1101.
2. LOAD VAL_IN=16'h1234, DP_IN=0 mid-frame:
   - Output is unchanged until the boundary; LOAD_ACK and FRAME pulse together, once.
   - Next frame: digit0 SEG=99, digit1 B0, digit2 A4, digit3 F9.
3. LZB=1 with VAL 16'h0050:
   - digit3 and digit2 SEG=FF with AN low.
   - digit1 SEG=92, digit0 SEG=C0.
   - VAL=0: only digit0 shows C0.
4. LOAD 16'hAAAA, then LOAD 16'hBEEF in the same frame, then DP_IN=4'b0001:
   - Only BEEF is committed, with a single LOAD_ACK.
   - digit0 SEG=0E (dot lit), digit3 SEG=03.
5. LOAD asserted exactly on the boundary cycle:
   - The value appears in the immediately following frame.
   - LOAD_ACK fires in the same cycle as FRAME.
6. RST pulsed during DRIVE of digit 2 with a pending load:
   - Next cycle AN=1111, SEG=FF, no LOAD_ACK.
   - Scan restarts at digit 0 showing C0.
